// File: rtl/dpram_stream_reader.sv
// Streams a block of 16-bit words out of a dpram read port (registered address, raw q) as valid/ready.
// Latency: start -> first out_valid 3 cycles; backpressure: out_ready low holds the head word and throttles reads.
module dpram_stream_reader #(
    parameter int ADDRWIDTH = 10,
    parameter int LENWIDTH  = ADDRWIDTH + 1
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] base_addr,
    input  logic [LENWIDTH-1:0]  length,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic [ADDRWIDTH-1:0] rd_addr,
    input  logic [15:0]          rd_q,
    output logic [15:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [ADDRWIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDRWIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [LENWIDTH-1:0]  remaining_q, remaining_d;

    // v1: address on rd_addr this cycle; v2: its data on rd_q this cycle. l* tag the final word.
    logic v1_q, v2_q, l1_q, l2_q;

    logic [16:0] fifo_mem_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  fifo_cnt_q;

    logic [1:0]  inflight;
    logic [16:0] head;
    logic        issue, push, pop;

    assign inflight  = {1'b0, v1_q} + {1'b0, v2_q};
    assign head      = fifo_mem_q[rd_ptr_q];
    assign out_valid = (fifo_cnt_q != 3'd0);
    assign out_data  = out_valid ? head[15:0] : 16'h0000;
    assign out_last  = out_valid & head[16];
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign rd_addr   = rd_addr_q;

    assign pop   = out_valid && out_ready && !abort;
    assign push  = v2_q && !abort;
    assign issue = (state_q == S_RUN) && !abort && (remaining_q != '0) &&
                   (({1'b0, fifo_cnt_q} + {2'b00, inflight}) < 4'd4);

    always_comb begin
        state_d     = state_q;
        next_addr_d = next_addr_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        state_d     = S_RUN;
                        next_addr_d = base_addr;
                        remaining_d = length;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                if (pop && head[16]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (issue) begin
            rd_addr_d   = next_addr_q;
            next_addr_d = next_addr_q + ADDRWIDTH'(1);
            remaining_d = remaining_q - LENWIDTH'(1);
        end
        // Abort overrides everything, including a start seen in the same cycle.
        if (abort) begin
            state_d     = S_IDLE;
            remaining_d = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            next_addr_q <= '0;
            rd_addr_q   <= '0;
            remaining_q <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            l1_q        <= 1'b0;
            l2_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            next_addr_q <= next_addr_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            v1_q        <= issue;
            l1_q        <= issue && (remaining_q == LENWIDTH'(1));
            v2_q        <= v1_q && !abort;
            l2_q        <= l1_q;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_q[i] <= 17'd0;
            end
        end else if (abort) begin
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            fifo_cnt_q <= 3'd0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= {l2_q, rd_q};
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 3'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 3'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_dpram_stream_reader.sv
// Directed bench for dpram_stream_reader: behavioural dpram model plus per-word stream checks.
module tb_dpram_stream_reader;

    logic        clk_sys;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic        abort;
    logic        busy;
    logic        done;
    logic [9:0]  rd_addr;
    logic [15:0] rd_q;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    int tests = 0;
    int fails = 0;

    logic [15:0] ram [1024];
    logic [9:0]  ram_addr_q;

    dpram_stream_reader #(.ADDRWIDTH(10), .LENWIDTH(11)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_q      (rd_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) ram_addr_q <= rd_addr;
    assign rd_q = ram[ram_addr_q];

    function automatic logic [15:0] expw(input logic [9:0] a);
        return {6'd0, a} ^ 16'hA5A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer: duty = percent of cycles with out_ready high; abort_at > 0 aborts after that
    // many accepted words; poke issues a second start mid-transfer that must be ignored.
    task automatic xfer(input logic [9:0] b, input int n, input int duty,
                        input int abort_at, input bit poke);
        int          got;
        int          first_v;
        bit          fin;
        bit          stalled;
        logic [15:0] held;
        logic        rdy;
        logic [9:0]  ea;
        @(negedge clk_sys);
        base_addr = b;
        length    = 11'(n);
        start     = 1'b1;
        out_ready = 1'b0;
        got = 0; first_v = -1; fin = 0; stalled = 0; held = '0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk_sys);
            start = 1'b0;
            if (poke && c == 3) begin
                start     = 1'b1;
                base_addr = 10'h200;
                length    = 11'd3;
            end
            check("occupancy_le4", 32'((dut.fifo_cnt_q + dut.v1_q + dut.v2_q) <= 4), 1);
            if (c == 0) check("busy_after_start", busy, 1);
            if (duty == 100 && c >= 1 && c <= 4 && c <= n) begin
                ea = b + 10'(c - 1);
                check("rd_addr_seq", rd_addr, ea);
            end
            if (out_valid && first_v < 0) begin
                first_v = c;
                check("first_valid_edge", c, 3);
            end
            if (stalled) begin
                check("stall_valid_hold", out_valid, 1);
                check("stall_data_hold", out_data, held);
            end
            if (abort_at > 0 && got == abort_at) begin
                abort     = 1'b1;
                out_ready = 1'b0;
                @(negedge clk_sys);
                abort = 1'b0;
                check("abort_valid", out_valid, 0);
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_sys);
                    check("post_abort_valid", out_valid, 0);
                    check("post_abort_done", done, 0);
                end
                fin = 1;
            end else if (done) begin
                check("done_busy_low", busy, 0);
                check("word_count", got, n);
                if (duty == 100) check("done_edge", c, n + 3);
                @(negedge clk_sys);
                check("done_one_cycle", done, 0);
                check("idle_valid_low", out_valid, 0);
                fin = 1;
            end else begin
                rdy       = ($urandom_range(0, 99) < duty);
                out_ready = rdy;
                stalled   = out_valid && !rdy;
                held      = out_data;
                if (out_valid) check("no_extra_word", 32'(got < n), 1);
                if (out_valid && rdy) begin
                    ea = b + 10'(got);
                    check("data", out_data, expw(ea));
                    check("last", out_last, 32'(got == n - 1));
                    got++;
                end
            end
        end
        check("xfer_finished", fin, 1);
        out_ready = 1'b0;
    endtask

    logic [9:0] a0;

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0;
        abort = 1'b0; out_ready = 1'b0; ram_addr_q = '0;
        for (int k = 0; k < 1024; k++) ram[k] = expw(10'(k));

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_rd_addr", rd_addr, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;

        xfer(10'h010, 8, 100, 0, 0);
        xfer(10'h3FE, 4, 100, 0, 0);
        xfer(10'h040, 16, 30, 0, 0);

        // Zero length: a single done pulse, no reads.
        @(negedge clk_sys);
        a0 = rd_addr;
        base_addr = 10'h155; length = 11'd0; start = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_valid", out_valid, 0);
        @(negedge clk_sys);
        check("len0_done_clear", done, 0);
        check("len0_busy2", busy, 0);
        check("len0_valid2", out_valid, 0);
        check("len0_rd_addr", rd_addr, a0);

        // Abort and start together in IDLE: start is dropped.
        @(negedge clk_sys);
        base_addr = 10'h0AA; length = 11'd4; start = 1'b1; abort = 1'b1;
        @(negedge clk_sys);
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_done", done, 0);
        @(negedge clk_sys);
        check("abort_start_busy2", busy, 0);
        check("abort_start_valid", out_valid, 0);

        xfer(10'h020, 32, 100, 5, 0);
        xfer(10'h100, 2, 100, 0, 0);
        xfer(10'h080, 12, 100, 0, 1);
        xfer(10'h3F0, 1024, 100, 0, 0);

        // Asynchronous reset between edges while streaming.
        @(negedge clk_sys);
        base_addr = 10'h000; length = 11'd32; start = 1'b1; out_ready = 1'b1;
        @(negedge clk_sys);
        start = 1'b0;
        repeat (5) @(negedge clk_sys);
        check("pre_reset_valid", out_valid, 1);
        @(posedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_last", out_last, 0);
        check("async_rst_rd_addr", rd_addr, 0);
        check("async_rst_done", done, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        out_ready = 1'b0;

        xfer(10'h3FF, 3, 100, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
